// File: rtl/clk_gen_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized osc_in rising edges over a window of clk cycles.
// Optional back-to-back measurement mode: define CLK_GEN_FREQ_METER_AUTO_RESTART_EN.
module clk_gen_freq_meter #(
    parameter int WINDOW_W    = 16,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                osc_in,
    input  logic [WINDOW_W-1:0] window_cycles_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                result_v_o,
    input  logic                result_yumi_i,
    output logic [COUNT_W-1:0]  result_count_o,
    output logic                overflow_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   osc_edge;
    logic [WINDOW_W-1:0]    win_cnt;
    logic [COUNT_W-1:0]     edge_cnt;
    logic                   ovf;
`ifdef CLK_GEN_FREQ_METER_AUTO_RESTART_EN
    logic [WINDOW_W-1:0]    win_len;
`endif

    // The chain runs in every state so the edge history is already valid when a window opens.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], osc_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign osc_edge = sync[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (window_cycles_i != '0) ? MEASURE : RESULT;
                end
            end
            MEASURE: begin
                if (win_cnt == WINDOW_W'(1)) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (result_yumi_i) begin
`ifdef CLK_GEN_FREQ_METER_AUTO_RESTART_EN
                    state_nxt = (win_len != '0) ? MEASURE : RESULT;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
`ifdef CLK_GEN_FREQ_METER_AUTO_RESTART_EN
            win_len  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        win_cnt  <= window_cycles_i;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
`ifdef CLK_GEN_FREQ_METER_AUTO_RESTART_EN
                        win_len  <= window_cycles_i;
`endif
                    end
                end
                MEASURE: begin
                    win_cnt <= win_cnt - WINDOW_W'(1);
                    if (osc_edge) begin
                        // Saturate rather than wrap; an edge lost to saturation is flagged.
                        if (&edge_cnt) begin
                            ovf <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + COUNT_W'(1);
                        end
                    end
                end
                RESULT: begin
`ifdef CLK_GEN_FREQ_METER_AUTO_RESTART_EN
                    if (result_yumi_i) begin
                        win_cnt  <= win_len;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // The count is not cleared on leaving RESULT, so the last result stays readable in IDLE.
    assign busy_o         = (state != IDLE);
    assign result_v_o     = (state == RESULT);
    assign result_count_o = edge_cnt;
    assign overflow_o     = ovf;

endmodule

// File: doc/clk_gen_freq_meter.md
Name: clk_gen_freq_meter

Overview:
- Measures the frequency of the free-running ring-oscillator output (`loop_out` of the inverter-chain stages).
- Counts oscillator rising edges over a programmable window of system-clock cycles.
- Presents the count with a valid/yumi handshake so the tuning controller can trim stage count.
- Sits between the tunable clock-gen ring and the tuning/readout logic; all logic is in the system-clock domain.

Parameters:
- WINDOW_W, 16: width of the measurement-window length input.
- COUNT_W, 16: width of the edge-count result.
- SYNC_STAGES, 2: flop depth of the osc_in synchronizer; minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- osc_in  input  1  ring-oscillator output; asynchronous to clk.
- window_cycles_i  input  WINDOW_W  measurement window length in clk cycles; sampled on start accept.
- start_i  input  1  measurement request; accepted only in IDLE.
- busy_o  output  1  high in MEASURE and RESULT.
- result_v_o  output  1  result valid.
- result_yumi_i  input  1  consumer takes the result; legal only when result_v_o=1.
- result_count_o  output  COUNT_W  rising-edge count for the last window.
- overflow_o  output  1  count saturated during the last window; qualified by result_v_o.

Behaviour:
- Reset state: FSM=IDLE; busy_o=0, result_v_o=0, result_count_o=0, overflow_o=0; synchronizer and edge-history flops=0; window counter=0.
- Synchronizer: SYNC_STAGES flops on osc_in, followed by one history flop.
  - edge = sync_last & ~hist.
  - Chain runs in every state, so edge history is valid on MEASURE entry.
- FSM states: IDLE, MEASURE, RESULT.
- IDLE:
  - start_i=1 and window_cycles_i!=0: next cycle MEASURE; win_cnt<=window_cycles_i; edge_cnt<=0; ovf<=0.
  - start_i=1 and window_cycles_i==0: next cycle RESULT with count 0, overflow 0.
- MEASURE: lasts exactly window_cycles_i clk cycles.
  - Each cycle: win_cnt decrements; if edge=1, edge_cnt increments.
  - Edge in the final MEASURE cycle is counted.
  - Transition to RESULT when win_cnt==1 (after that cycle's update).
- Saturation: edge_cnt at all-ones stays all-ones; an edge while saturated sets ovf=1; ovf is sticky until the next start.
- RESULT:
  - result_v_o=1; result_count_o and overflow_o held stable until result_yumi_i=1.
  - On yumi: next cycle IDLE, result_v_o=0.
  - result_count_o keeps its last value in IDLE; it is not cleared.
- start_i outside IDLE: ignored, not queued.
- result_yumi_i outside RESULT: ignored.
- Accuracy: ±1 edge versus the ideal count, from synchronizer phase uncertainty.
- Oscillator frequency must be below clk/2 for a valid count; faster input aliases and is not detected.
- Reset asserted mid-MEASURE or mid-RESULT: next cycle matches reset state; any partial count is discarded.

Optional Feature:
- Macro: CLK_GEN_FREQ_METER_AUTO_RESTART_EN.
- Defined:
  - In RESULT, result_yumi_i=1 moves directly to MEASURE the next cycle with the previously latched window length, edge_cnt=0 and ovf=0. This gives back-to-back measurements with no IDLE gap.
  - Latched window of 0 goes to RESULT instead, as from IDLE.
  - The meter returns to IDLE only on reset.
  - start_i is used only for the first measurement after reset.
- Undefined: yumi returns the FSM to IDLE, as described in Behaviour.

Test Plan:
- Window limits: window=100, osc toggled on clk negedge every 2 clk cycles (clk/4, low at start) -> MEASURE lasts 100 cycles; result_v_o asserts the cycle after; count=25 (±1 allowed); overflow_o=0.
- Zero window: window_cycles_i=0 with start pulse -> result_v_o=1 the next cycle; count=0; busy_o=1 until yumi.
- Saturation: COUNT_W=4, window=100, osc clk/4 -> count=15, overflow_o=1.
- Backpressure and ignored inputs: hold result_yumi_i=0 for 10 cycles and pulse start_i meanwhile -> result stable and start ignored; yumi -> IDLE next cycle; a new start is then accepted.
- Reset mid-operation: assert reset at cycle 40 of a 100-cycle window -> next cycle busy_o=0, result_v_o=0, result_count_o=0; a fresh start gives a full correct window.
- Auto-restart (macro defined): window=50, osc clk/4, yumi on each result -> results are back-to-back with 1-cycle spacing; each count=12 or 13; busy_o never drops.
